// File: rtl/uart_host_pkg.sv
// rtl/uart_host_pkg.sv - shared constants and FSM state types for uart_host_buffer
package uart_host_pkg;

  localparam logic [7:0] XON  = 8'h11;
  localparam logic [7:0] XOFF = 8'h13;

  localparam int FE = 0;
  localparam int PE = 1;
  localparam int OE = 2;

  typedef enum logic {R_IDLE, R_WAIT} rx_state_t;
  typedef enum logic {T_IDLE, T_LOAD} tx_state_t;

endpackage

// File: rtl/uart_host_buffer_if.sv
// rtl/uart_host_buffer_if.sv - UART-side and CPU-side signal bundle of uart_host_buffer
interface uart_host_buffer_if #(parameter int DEPTH_LOG2 = 4);

  logic [7:0]          u_rr;
  logic                u_dr;
  logic                u_fe;
  logic                u_pe;
  logic                u_oe;
  logic                u_drr;
  logic [7:0]          u_tr;
  logic                u_thrl;
  logic                u_thre;
  logic [7:0]          rd_data;
  logic [2:0]          rd_flags;
  logic                rd_valid;
  logic                rd_ack;
  logic [7:0]          tx_data;
  logic                tx_req;
  logic                tx_ack;
  logic                flow_en;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;
  logic                clr_ovf;

  modport master (
    output u_rr, u_dr, u_fe, u_pe, u_oe, u_thre, rd_ack, tx_data, tx_req, flow_en, clr_ovf,
    input  u_drr, u_tr, u_thrl, rd_data, rd_flags, rd_valid, tx_ack, count, overflow
  );

  modport slave (
    input  u_rr, u_dr, u_fe, u_pe, u_oe, u_thre, rd_ack, tx_data, tx_req, flow_en, clr_ovf,
    output u_drr, u_tr, u_thrl, rd_data, rd_flags, rd_valid, tx_ack, count, overflow
  );

endinterface

// File: rtl/vt_sync_fifo.sv
// rtl/vt_sync_fifo.sv - first-word fall-through synchronous FIFO with fill count
module vt_sync_fifo #(
  parameter int WIDTH      = 11,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  output logic                  push_ok,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  valid,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int                  DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL  = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  pop_ok;

  assign valid    = (count != '0);
  assign pop_ok   = pop && valid;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign push_ok  = push && ((count != FULL) || pop_ok);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_host_buffer.sv
// rtl/uart_host_buffer.sv - UART receive buffering, CPU transmit and XON/XOFF arbitration
module uart_host_buffer
  import uart_host_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int HI_MARK    = 12,
  parameter int LO_MARK    = 4
) (
  input logic               clk,
  input logic               reset,
  uart_host_buffer_if.slave bus
);

  localparam int            CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] HI = CW'(HI_MARK);
  localparam logic [CW-1:0] LO = CW'(LO_MARK);

  rx_state_t   r_state;
  tx_state_t   t_state;
  logic        push;
  logic        push_ok;
  logic [10:0] head;
  logic        xoff_sent;
  logic        pend_xoff;
  logic        pend_xon;
  logic        xoff_cond;
  logic        xon_cond;

  assign push = (r_state == R_IDLE) && bus.u_dr;

  vt_sync_fifo #(.WIDTH(11), .DEPTH_LOG2(DEPTH_LOG2)) rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({bus.u_oe, bus.u_pe, bus.u_fe, bus.u_rr}),
    .push_ok   (push_ok),
    .pop       (bus.rd_ack),
    .pop_data  (head),
    .valid     (bus.rd_valid),
    .count     (bus.count)
  );

  assign bus.rd_data  = head[7:0];
  assign bus.rd_flags = head[10:8];

  // u_drr follows the capture by one cycle; R_WAIT holds until the UART has let go of u_dr.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= R_IDLE;
      bus.u_drr    <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      bus.u_drr <= push;
      case (r_state)
        R_IDLE:  if (bus.u_dr) r_state <= R_WAIT;
        R_WAIT:  if (!bus.u_dr && !bus.u_drr) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
      if (push && !push_ok)  bus.overflow <= 1'b1;
      else if (bus.clr_ovf)  bus.overflow <= 1'b0;
    end
  end

  assign xoff_cond = bus.flow_en && (bus.count >= HI) && !xoff_sent;
  assign xon_cond  = xoff_sent && ((bus.count <= LO) || !bus.flow_en);

  // Pending flags are re-evaluated every cycle, so a stale XOFF request drops out on its own.
  always_ff @(posedge clk) begin
    if (reset) begin
      t_state    <= T_IDLE;
      bus.u_tr   <= 8'h00;
      bus.u_thrl <= 1'b0;
      bus.tx_ack <= 1'b0;
      xoff_sent  <= 1'b0;
      pend_xoff  <= 1'b0;
      pend_xon   <= 1'b0;
    end else begin
      pend_xoff  <= xoff_cond;
      pend_xon   <= xon_cond;
      bus.u_thrl <= 1'b0;
      bus.tx_ack <= 1'b0;
      case (t_state)
        T_IDLE: begin
          if (bus.u_thre) begin
            if (pend_xoff || pend_xon) begin
              bus.u_tr   <= pend_xoff ? XOFF : XON;
              xoff_sent  <= pend_xoff;
              pend_xoff  <= 1'b0;
              pend_xon   <= 1'b0;
              bus.u_thrl <= 1'b1;
              t_state    <= T_LOAD;
            end else if (bus.tx_req) begin
              bus.u_tr   <= bus.tx_data;
              bus.u_thrl <= 1'b1;
              bus.tx_ack <= 1'b1;
              t_state    <= T_LOAD;
            end
          end
        end
        T_LOAD:  t_state <= T_IDLE;
        default: t_state <= T_IDLE;
      endcase
    end
  end

endmodule
